sram_data_arbiter: RTL and testbench
====================================

Name: sram_data_arbiter

Overview:
- Two-requester arbiter for the single on-chip data SRAM port in the core data subsystem.
- Requester 0 is the core data path after the address decoder has selected SRAM. Requester 1 is the AXI-slave adapter, which carries external master traffic into SRAM.
- Arbitrates request by request with round-robin fairness under contention.
- Tracks in-flight accesses in a fixed-latency response pipeline and returns each response to the requester that issued the access.

Parameters:
- ADDR_WIDTH, 32, byte address width on all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- SRAM_LATENCY, 1, cycles from SRAM request to read data valid. Legal range 1..3; any other value is an elaboration error.

Ports:
- clk_i  in  1  system clock, rising edge.
- reset_i  in  1  asynchronous reset, active-low.
- core_req_i  in  1  core requests an access.
- core_gnt_o  out  1  core request accepted this cycle.
- core_we_i  in  1  1=write, 0=read.
- core_be_i  in  DATA_WIDTH/8  byte enables.
- core_addr_i  in  ADDR_WIDTH  byte address.
- core_wdata_i  in  DATA_WIDTH  write data.
- core_rvalid_o  out  1  response valid for an earlier core grant.
- core_rdata_o  out  DATA_WIDTH  read data; 0 for write responses.
- axi_req_i, axi_gnt_o, axi_we_i, axi_be_i, axi_addr_i, axi_wdata_i, axi_rvalid_o, axi_rdata_o: same directions, widths and meanings as the core_* set, for the AXI-slave adapter.
- sram_req_o  out  1  SRAM access strobe.
- sram_we_o  out  1  SRAM write enable.
- sram_be_o  out  DATA_WIDTH/8  SRAM byte enables.
- sram_addr_o  out  ADDR_WIDTH  SRAM byte address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_rdata_i  in  DATA_WIDTH  read data, valid exactly SRAM_LATENCY cycles after sram_req_o.

Behaviour:
- Request protocol:
  - A requester holds req and its attributes stable until it sees gnt=1 in the same cycle.
  - Grant is combinational from req and the arbiter state.
  - The SRAM never stalls, so at most one grant is issued per cycle.
  - Every grant produces exactly one rvalid pulse, for both reads and writes.
- Arbitration:
  - Exactly one requester active: it is granted immediately.
  - Both active: the requester selected by the round-robin flag rr_q wins.
  - rr_q is 0 for core, 1 for AXI. On each grant, rr_q flips to point at the requester that was *not* granted.
  - Sustained contention therefore alternates C,A,C,A...
  - Neither active: rr_q holds.
- SRAM drive:
  - sram_req_o = core_gnt_o | axi_gnt_o.
  - sram_we/be/addr/wdata are muxed from the granted requester; all are 0 when idle.
- Response pipeline:
  - Shift register of depth SRAM_LATENCY; each entry holds {valid, owner, we}.
  - Stage 0 loads {sram_req_o, granted id, granted we} every cycle.
  - At the last stage, owner selects which rvalid is asserted.
  - rdata = sram_rdata_i for reads and 0 for writes. The non-owner rvalid is 0 and its rdata is 0.
  - Latency: grant in cycle N gives rvalid in cycle N+SRAM_LATENCY.
  - Responses are in order per requester and globally. Back-to-back grants give back-to-back rvalids.
- Contention counter:
  - Internal 16-bit saturating count of cycles where both reqs are high; saturates at 0xFFFF.
  - Exposed only as a debug signal for the bench, not as a port.
- Reset:
  - Asserted (reset_i=0): all gnt_o, rvalid_o and sram_* outputs are 0, overriding any req inputs.
  - Also on reset: pipeline valids cleared, rr_q=0 (core preferred), contention counter 0.
  - Reset in the middle of an access: in-flight responses are dropped with no rvalid after deassertion. Requesters must reissue.
- Simultaneous events:
  - A new grant in the same cycle as an rvalid to the same requester is legal and must not be blocked.
  - A req deasserted without a grant is legal; no state changes.

Test Plan:
- Core-only read: reset, core_req=1, addr=0x0000_0010, we=0, SRAM model returns 0xDEADBEEF → core_gnt same cycle; core_rvalid exactly SRAM_LATENCY cycles later with rdata=0xDEADBEEF; axi_rvalid stays 0.
- AXI-only write: axi_we=1, be=4'b0011, addr=0x20, wdata=0x1234_5678 → sram_we=1, be=0011, addr=0x20; axi_rvalid after latency with rdata=0.
- Sustained contention, 8 cycles, both reqs held with new addresses each grant → grant order C,A,C,A,C,A,C,A; responses routed to the matching owner in the same order; contention counter=8.
- Latency sweep: SRAM_LATENCY=1,2,3, 4 back-to-back core reads → 4 consecutive rvalid cycles starting at N+L; per-beat data matches the SRAM model.
- Reset mid-flight: SRAM_LATENCY=3, grant AXI read, assert reset_i=0 one cycle later for 2 cycles → no rvalid after release; rr_q=0, so the next contended cycle grants core.
- Idle and default checks: no reqs for 10 cycles → all sram_* outputs 0; rr_q unchanged.

Source files
------------

// File: rtl/sram_data_arbiter.sv
// -----------------------------------------------------------------------------
// sram_data_arbiter
//
// Shares the single on-chip data SRAM port between two requesters:
//   requester 0 - core data path (after the address decoder selected SRAM)
//   requester 1 - AXI-slave adapter (external master traffic)
//
// Arbitration is per request. A lone requester is granted at once; under
// contention a round-robin flag alternates the winner. Every grant launches
// one SRAM access. A fixed-latency response pipeline remembers which
// requester issued each access and whether it was a write, so the SRAM read
// data (or zero for writes) is routed back to the right requester.
//
// Ports:
//   clk_i, reset_i              clock (rising edge), async reset (active low)
//   core_req_i / core_gnt_o     core request / same-cycle acceptance
//   core_we_i, core_be_i,       core access attributes (write enable, byte
//   core_addr_i, core_wdata_i   enables, byte address, write data)
//   core_rvalid_o, core_rdata_o core response strobe and read data
//   axi_*                       identical set for the AXI-slave adapter
//   sram_req_o, sram_we_o,      SRAM access strobe and attributes of the
//   sram_be_o, sram_addr_o,     granted requester (all zero when idle)
//   sram_wdata_o
//   sram_rdata_i                SRAM read data, SRAM_LATENCY cycles after req
// -----------------------------------------------------------------------------
module sram_data_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SRAM_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    core_req_i,
    output logic                    core_gnt_o,
    input  logic                    core_we_i,
    input  logic [DATA_WIDTH/8-1:0] core_be_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,

    input  logic                    axi_req_i,
    output logic                    axi_gnt_o,
    input  logic                    axi_we_i,
    input  logic [DATA_WIDTH/8-1:0] axi_be_i,
    input  logic [ADDR_WIDTH-1:0]   axi_addr_i,
    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
    output logic                    axi_rvalid_o,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o,

    output logic                    sram_req_o,
    output logic                    sram_we_o,
    output logic [DATA_WIDTH/8-1:0] sram_be_o,
    output logic [ADDR_WIDTH-1:0]   sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   sram_rdata_i
);

    localparam int LAST = SRAM_LATENCY - 1;

    generate
        if (SRAM_LATENCY < 1 || SRAM_LATENCY > 3) begin : g_bad_latency
            $error("sram_data_arbiter: SRAM_LATENCY must be in 1..3");
        end
    endgenerate

    // Round-robin flag: 0 = core wins the next contended cycle, 1 = AXI.
    logic        rr_q;
    // Saturating count of contended cycles, kept for debug observation.
    logic [15:0] contention_cnt_q;

    // Response pipeline, bit 0 is the newest stage, bit LAST the oldest.
    logic [SRAM_LATENCY-1:0] pipe_valid_q;
    logic [SRAM_LATENCY-1:0] pipe_owner_q;
    logic [SRAM_LATENCY-1:0] pipe_we_q;

    logic                  both_req;
    logic                  resp_valid;
    logic                  resp_owner;
    logic [DATA_WIDTH-1:0] resp_data;

    assign both_req = core_req_i & axi_req_i;

    // Grant decision. Reset forces both grants low so nothing reaches the
    // SRAM while reset is held, whatever the requesters are doing.
    always_comb begin
        core_gnt_o = 1'b0;
        axi_gnt_o  = 1'b0;
        if (reset_i) begin
            if (both_req) begin
                core_gnt_o = ~rr_q;
                axi_gnt_o  = rr_q;
            end else begin
                core_gnt_o = core_req_i;
                axi_gnt_o  = axi_req_i;
            end
        end
    end

    assign sram_req_o = core_gnt_o | axi_gnt_o;

    // SRAM attribute mux; idle cycles drive zeros rather than stale values.
    always_comb begin
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (core_gnt_o) begin
            sram_we_o    = core_we_i;
            sram_be_o    = core_be_i;
            sram_addr_o  = core_addr_i;
            sram_wdata_o = core_wdata_i;
        end else if (axi_gnt_o) begin
            sram_we_o    = axi_we_i;
            sram_be_o    = axi_be_i;
            sram_addr_o  = axi_addr_i;
            sram_wdata_o = axi_wdata_i;
        end
    end

    // After every grant the flag points at the requester that lost, so
    // sustained contention alternates; with no grant the flag holds.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rr_q <= 1'b0;
        end else if (core_gnt_o) begin
            rr_q <= 1'b1;
        end else if (axi_gnt_o) begin
            rr_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            contention_cnt_q <= '0;
        end else if (both_req && (contention_cnt_q != 16'hFFFF)) begin
            contention_cnt_q <= contention_cnt_q + 16'd1;
        end
    end

    // Stage 0 loads the current access every cycle; the shift moves older
    // accesses toward the output. Reset empties the pipe so in-flight
    // accesses never produce a response afterwards.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pipe_valid_q <= '0;
            pipe_owner_q <= '0;
            pipe_we_q    <= '0;
        end else begin
            pipe_valid_q <= (pipe_valid_q << 1) | SRAM_LATENCY'(sram_req_o);
            pipe_owner_q <= (pipe_owner_q << 1) | SRAM_LATENCY'(axi_gnt_o);
            pipe_we_q    <= (pipe_we_q << 1)    | SRAM_LATENCY'(sram_we_o);
        end
    end

    assign resp_valid = pipe_valid_q[LAST];
    assign resp_owner = pipe_owner_q[LAST];
    assign resp_data  = pipe_we_q[LAST] ? '0 : sram_rdata_i;

    assign core_rvalid_o = resp_valid & ~resp_owner;
    assign axi_rvalid_o  = resp_valid & resp_owner;
    assign core_rdata_o  = core_rvalid_o ? resp_data : '0;
    assign axi_rdata_o   = axi_rvalid_o ? resp_data : '0;

endmodule

// File: tb/tb_sram_data_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_data_arbiter
//
// Drives three arbiter instances (SRAM_LATENCY = 1, 2, 3) with the same
// requester traffic. Each instance has its own SRAM model whose read data is
// a fixed function of the address requested L cycles earlier. The stimulus
// side predicts grants and SRAM drive from the arbitration rules and queues
// the expected response of every grant; a separate monitor matches the
// responses of each instance against that queue.
// -----------------------------------------------------------------------------
module tb_sram_data_arbiter;

    localparam int NL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n      = 1'b1;
    logic        core_req   = 1'b0;
    logic        core_we    = 1'b0;
    logic [3:0]  core_be    = '0;
    logic [31:0] core_addr  = '0;
    logic [31:0] core_wdata = '0;
    logic        axi_req    = 1'b0;
    logic        axi_we     = 1'b0;
    logic [3:0]  axi_be     = '0;
    logic [31:0] axi_addr   = '0;
    logic [31:0] axi_wdata  = '0;

    logic        core_gnt    [NL];
    logic        axi_gnt     [NL];
    logic        core_rvalid [NL];
    logic        axi_rvalid  [NL];
    logic [31:0] core_rdata  [NL];
    logic [31:0] axi_rdata   [NL];
    logic        sram_req    [NL];
    logic        sram_we     [NL];
    logic [3:0]  sram_be     [NL];
    logic [31:0] sram_addr   [NL];
    logic [31:0] sram_wdata  [NL];
    logic [31:0] sram_rdata  [NL];
    logic        dbg_rr      [NL];
    logic [15:0] dbg_cnt     [NL];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Read data the SRAM model returns for a given address.
    function automatic logic [31:0] sram_word(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    generate
        for (genvar g = 0; g < NL; g++) begin : g_lane
            logic [31:0] addr_pipe [0:g];

            sram_data_arbiter #(
                .ADDR_WIDTH  (32),
                .DATA_WIDTH  (32),
                .SRAM_LATENCY(g + 1)
            ) dut (
                .clk_i        (clk),
                .reset_i      (rst_n),
                .core_req_i   (core_req),
                .core_gnt_o   (core_gnt[g]),
                .core_we_i    (core_we),
                .core_be_i    (core_be),
                .core_addr_i  (core_addr),
                .core_wdata_i (core_wdata),
                .core_rvalid_o(core_rvalid[g]),
                .core_rdata_o (core_rdata[g]),
                .axi_req_i    (axi_req),
                .axi_gnt_o    (axi_gnt[g]),
                .axi_we_i     (axi_we),
                .axi_be_i     (axi_be),
                .axi_addr_i   (axi_addr),
                .axi_wdata_i  (axi_wdata),
                .axi_rvalid_o (axi_rvalid[g]),
                .axi_rdata_o  (axi_rdata[g]),
                .sram_req_o   (sram_req[g]),
                .sram_we_o    (sram_we[g]),
                .sram_be_o    (sram_be[g]),
                .sram_addr_o  (sram_addr[g]),
                .sram_wdata_o (sram_wdata[g]),
                .sram_rdata_i (sram_rdata[g])
            );

            // SRAM model: data for the address presented L cycles ago.
            always @(posedge clk) begin
                addr_pipe[0] <= sram_addr[g];
                for (int i = 1; i <= g; i++) addr_pipe[i] <= addr_pipe[i-1];
            end
            assign sram_rdata[g] = sram_word(addr_pipe[g]);

            assign dbg_rr[g]  = dut.rr_q;
            assign dbg_cnt[g] = dut.contention_cnt_q;
        end
    endgenerate

    typedef struct {
        bit          owner;
        logic [31:0] data;
        int          gcyc;
    } rsp_t;

    rsp_t exp_q [$];
    int   rd_idx [NL];
    int   last_rst = -1;

    int checks = 0;
    int passes = 0;

    bit          model_pref = 1'b0;
    int          model_cnt  = 0;
    bit          last_gc, last_ga;
    logic [7:0]  order_log;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                      name, actual, expected, cyc);
    endtask

    // Evaluate the current cycle (inputs already driven), compare grants and
    // SRAM drive, queue the expected response, then advance one clock.
    task automatic applyStimulus();
        bit          gc, ga;
        logic [71:0] exp_bus;
        rsp_t        r;
        #1;
        gc = 1'b0;
        ga = 1'b0;
        if (!rst_n) begin
            last_rst   = cyc;
            model_pref = 1'b0;
            model_cnt  = 0;
        end else begin
            if (core_req && axi_req && model_cnt < 65535) model_cnt++;
            gc = core_req && (!axi_req || !model_pref);
            ga = axi_req && !gc;
        end
        if (gc)      exp_bus = {1'b1, 1'b0, 1'b1, core_we, core_be, core_addr, core_wdata};
        else if (ga) exp_bus = {1'b0, 1'b1, 1'b1, axi_we, axi_be, axi_addr, axi_wdata};
        else         exp_bus = '0;
        for (int k = 0; k < NL; k++)
            checkOutput($sformatf("grant/sram lane%0d", k),
                        128'({core_gnt[k], axi_gnt[k], sram_req[k], sram_we[k],
                              sram_be[k], sram_addr[k], sram_wdata[k]}),
                        128'(exp_bus));
        if (rst_n && core_req && axi_req) order_log = {order_log[6:0], axi_gnt[0]};
        if (gc || ga) begin
            r.owner = ga;
            r.gcyc  = cyc;
            if (gc) r.data = core_we ? 32'h0 : sram_word(core_addr);
            else    r.data = axi_we  ? 32'h0 : sram_word(axi_addr);
            exp_q.push_back(r);
            model_pref = gc;
        end
        last_gc = gc;
        last_ga = ga;
        @(negedge clk);
    endtask

    task automatic setCore(input bit we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        core_req = 1'b1; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
    endtask

    task automatic setAxi(input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata);
        axi_req = 1'b1; axi_we = we; axi_be = be; axi_addr = addr; axi_wdata = wdata;
    endtask

    task automatic randCore();
        setCore(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
    endtask

    task automatic randAxi();
        setAxi(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
    endtask

    // Monitor: each instance must answer every queued grant exactly
    // L cycles later, and stay silent otherwise.
    initial begin
        rsp_t e;
        for (int k = 0; k < NL; k++) rd_idx[k] = 0;
        forever begin
            @(negedge clk);
            #3;
            for (int k = 0; k < NL; k++) begin
                if (rd_idx[k] < exp_q.size() && exp_q[rd_idx[k]].gcyc + k + 1 == cyc) begin
                    e = exp_q[rd_idx[k]];
                    rd_idx[k]++;
                    if (last_rst > e.gcyc)
                        checkOutput($sformatf("dropped rsp lane%0d", k),
                                    128'({core_rvalid[k], axi_rvalid[k]}), 128'(2'b00));
                    else if (e.owner)
                        checkOutput($sformatf("axi rsp lane%0d", k),
                                    128'({core_rvalid[k], axi_rvalid[k], core_rdata[k], axi_rdata[k]}),
                                    128'({1'b0, 1'b1, 32'h0, e.data}));
                    else
                        checkOutput($sformatf("core rsp lane%0d", k),
                                    128'({core_rvalid[k], axi_rvalid[k], core_rdata[k], axi_rdata[k]}),
                                    128'({1'b1, 1'b0, e.data, 32'h0}));
                end else if (core_rvalid[k] || axi_rvalid[k] ||
                             core_rdata[k] != 32'h0 || axi_rdata[k] != 32'h0) begin
                    checkOutput($sformatf("spurious rsp lane%0d", k),
                                128'({core_rvalid[k], axi_rvalid[k], core_rdata[k], axi_rdata[k]}),
                                128'(0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit saved_pref;
        @(negedge clk);

        // Reset with requests asserted: nothing may be granted.
        rst_n = 1'b0;
        setCore(1'b0, 4'hF, 32'h100, 32'h0);
        setAxi(1'b1, 4'hF, 32'h104, 32'h55);
        repeat (3) applyStimulus();
        for (int k = 0; k < NL; k++) begin
            checkOutput($sformatf("reset rr lane%0d", k), 128'(dbg_rr[k]), 128'(0));
            checkOutput($sformatf("reset cnt lane%0d", k), 128'(dbg_cnt[k]), 128'(0));
        end
        core_req = 1'b0;
        axi_req  = 1'b0;
        rst_n    = 1'b1;
        applyStimulus();

        // Core-only read of 0x10.
        setCore(1'b0, 4'hF, 32'h0000_0010, 32'h0);
        applyStimulus();
        core_req = 1'b0;
        repeat (4) applyStimulus();

        // AXI-only partial write.
        setAxi(1'b1, 4'b0011, 32'h0000_0020, 32'h1234_5678);
        applyStimulus();
        axi_req = 1'b0;
        repeat (4) applyStimulus();

        // Sustained contention for 8 cycles, new transaction after each grant.
        order_log = '0;
        randCore();
        randAxi();
        repeat (8) begin
            applyStimulus();
            if (last_gc) randCore();
            if (last_ga) randAxi();
        end
        core_req = 1'b0;
        axi_req  = 1'b0;
        checkOutput("contention order", 128'(order_log), 128'(8'b0101_0101));
        for (int k = 0; k < NL; k++)
            checkOutput($sformatf("contention cnt lane%0d", k), 128'(dbg_cnt[k]), 128'(16'd8));
        repeat (4) applyStimulus();

        // Four back-to-back core reads.
        for (int i = 0; i < 4; i++) begin
            setCore(1'b0, 4'hF, 32'h0000_0200 + 32'(i * 4), 32'h0);
            applyStimulus();
        end
        core_req = 1'b0;

        // Idle: SRAM outputs zero, round-robin flag holds.
        saved_pref = model_pref;
        repeat (10) applyStimulus();
        for (int k = 0; k < NL; k++)
            checkOutput($sformatf("idle rr hold lane%0d", k), 128'(dbg_rr[k]), 128'(saved_pref));

        // Reset in flight: core then AXI read granted, reset on the next cycle.
        setCore(1'b0, 4'hF, 32'h0000_0300, 32'h0);
        applyStimulus();
        core_req = 1'b0;
        setAxi(1'b0, 4'hF, 32'h0000_0340, 32'h0);
        applyStimulus();
        axi_req = 1'b0;
        setCore(1'b0, 4'hF, 32'h0000_0344, 32'h0);
        rst_n = 1'b0;
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        for (int k = 0; k < NL; k++)
            checkOutput($sformatf("post-reset rr lane%0d", k), 128'(dbg_rr[k]), 128'(0));
        repeat (4) applyStimulus();

        // Core grant leaves AXI preferred; reset must restore core preference.
        applyStimulus();
        core_req = 1'b0;
        rst_n = 1'b0;
        applyStimulus();
        rst_n = 1'b1;
        setCore(1'b0, 4'hF, 32'h0000_0400, 32'h0);
        setAxi(1'b0, 4'hF, 32'h0000_0404, 32'h0);
        #1;
        checkOutput("post-reset winner", 128'({core_gnt[2], axi_gnt[2]}), 128'(2'b10));
        applyStimulus();
        core_req = 1'b0;
        applyStimulus();
        axi_req = 1'b0;
        repeat (4) applyStimulus();

        // Random traffic, including occasional withdrawn requests.
        repeat (300) begin
            if (!core_req && $urandom_range(0, 1) == 1) randCore();
            if (!axi_req && $urandom_range(0, 1) == 1) randAxi();
            applyStimulus();
            if (last_gc) core_req = 1'b0;
            else if (core_req && $urandom_range(0, 15) == 0) core_req = 1'b0;
            if (last_ga) axi_req = 1'b0;
            else if (axi_req && $urandom_range(0, 15) == 0) axi_req = 1'b0;
        end
        core_req = 1'b0;
        axi_req  = 1'b0;
        repeat (6) applyStimulus();

        for (int k = 0; k < NL; k++) begin
            checkOutput($sformatf("all rsp seen lane%0d", k), 128'(rd_idx[k]), 128'(exp_q.size()));
            checkOutput($sformatf("final cnt lane%0d", k), 128'(dbg_cnt[k]), 128'(model_cnt));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
